// File: rtl/vga_pkg.sv
// Shared screen geometry, PS/2 status-byte layout and tracker state encoding.
package vga_pkg;

  localparam int H_RES = 1024;
  localparam int V_RES = 768;
  localparam int POS_W = 12;

  localparam int ST_LEFT   = 0;
  localparam int ST_RIGHT  = 1;
  localparam int ST_SYNC   = 3;
  localparam int ST_X_SIGN = 4;
  localparam int ST_Y_SIGN = 5;
  localparam int ST_X_OVF  = 6;
  localparam int ST_Y_OVF  = 7;

  typedef enum logic [1:0] {
    WAIT_B0,
    WAIT_B1,
    WAIT_B2,
    UPDATE
  } tracker_state_t;

  // 9-bit PS/2 delta sign-extended to 10 bits so the caller can negate -256 safely.
  function automatic logic signed [9:0] ps2_delta(input logic sign, input logic ovf,
                                                  input logic [7:0] data);
    if (ovf) return '0;
    return {sign, sign, data};
  endfunction

endpackage

// File: rtl/mouse_clamp.sv
// Accumulates a signed delta onto an unsigned position and saturates to 0..max.
module mouse_clamp
  import vga_pkg::*;
(
  input  logic [POS_W-1:0] pos,
  input  logic signed [9:0] delta,
  input  logic [POS_W-1:0] max,
  output logic [POS_W-1:0] pos_clamped
);

  logic signed [13:0] sum;
  logic signed [13:0] limit;

  always_comb begin
    sum   = $signed({2'b00, pos}) + $signed({{4{delta[9]}}, delta});
    limit = $signed({2'b00, max});
    if (sum < 0)
      pos_clamped = '0;
    else if (sum > limit)
      pos_clamped = max;
    else
      pos_clamped = sum[POS_W-1:0];
  end

endmodule

// File: rtl/mouse_tracker.sv
// PS/2 three-byte packet parser that maintains an absolute, screen-clamped cursor.
//
// state   | meaning
// WAIT_B0 | idle, expecting a status byte with the sync bit set
// WAIT_B1 | status held, expecting X delta (idle timeout armed)
// WAIT_B2 | X held, expecting Y delta (idle timeout armed)
// UPDATE  | one cycle: apply deltas, register outputs, pulse pos_valid
module mouse_tracker
  import vga_pkg::*;
#(
  parameter int X_MAX   = H_RES - 1,
  parameter int Y_MAX   = V_RES - 1,
  parameter int TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic             left_mouse,
  output logic             right_mouse,
  output logic             pos_valid,
  output logic             pkt_error
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

  tracker_state_t   state, state_nx;
  logic [7:0]       status_q, status_nx;
  logic [7:0]       dx_q, dx_nx;
  logic [7:0]       dy_q, dy_nx;
  logic [CNT_W-1:0] idle_q, idle_nx;
  logic             err_nx;
  logic             upd;

  logic signed [9:0] dx, dy, dy_neg;
  logic [POS_W-1:0]  x_new, y_new;
  logic              unused_status;

  assign unused_status = ^status_q[3:2];

  always_comb begin
    state_nx  = state;
    status_nx = status_q;
    dx_nx     = dx_q;
    dy_nx     = dy_q;
    idle_nx   = '0;
    err_nx    = 1'b0;
    upd       = 1'b0;
    case (state)
      WAIT_B0: begin
        if (rx_valid) begin
          if (rx_data[ST_SYNC]) begin
            status_nx = rx_data;
            state_nx  = WAIT_B1;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      WAIT_B1, WAIT_B2: begin
        if (rx_valid) begin
          if (state == WAIT_B1) begin
            dx_nx    = rx_data;
            state_nx = WAIT_B2;
          end else begin
            dy_nx    = rx_data;
            state_nx = UPDATE;
          end
        end else if (idle_q == IDLE_LAST) begin
          state_nx = WAIT_B0;
          err_nx   = 1'b1;
        end else begin
          idle_nx = idle_q + CNT_W'(1);
        end
      end
      UPDATE: begin
        state_nx = WAIT_B0;
        upd      = 1'b1;
      end
      default: state_nx = WAIT_B0;
    endcase
  end

  // PS/2 reports +Y as up, screen Y grows downward.
  assign dx     = ps2_delta(status_q[ST_X_SIGN], status_q[ST_X_OVF], dx_q);
  assign dy     = ps2_delta(status_q[ST_Y_SIGN], status_q[ST_Y_OVF], dy_q);
  assign dy_neg = -dy;

  mouse_clamp u_clamp_x (
    .pos         (xpos),
    .delta       (dx),
    .max         (POS_W'(X_MAX)),
    .pos_clamped (x_new)
  );

  mouse_clamp u_clamp_y (
    .pos         (ypos),
    .delta       (dy_neg),
    .max         (POS_W'(Y_MAX)),
    .pos_clamped (y_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_B0;
      status_q    <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      idle_q      <= '0;
      xpos        <= POS_W'(X_MAX / 2);
      ypos        <= POS_W'(Y_MAX / 2);
      left_mouse  <= 1'b0;
      right_mouse <= 1'b0;
      pos_valid   <= 1'b0;
      pkt_error   <= 1'b0;
    end else begin
      state     <= state_nx;
      status_q  <= status_nx;
      dx_q      <= dx_nx;
      dy_q      <= dy_nx;
      idle_q    <= idle_nx;
      pos_valid <= upd;
      pkt_error <= err_nx;
      if (upd) begin
        xpos        <= x_new;
        ypos        <= y_new;
        left_mouse  <= status_q[ST_LEFT];
        right_mouse <= status_q[ST_RIGHT];
      end
    end
  end

endmodule

// File: doc/mouse_tracker.md
MOUSE_TRACKER -- requirements
Module: mouse_tracker

Interface
REQ-001 SHALL have parameter X_MAX, default 1023: maximum xpos value (pixels).
REQ-002 SHALL have parameter Y_MAX, default 767: maximum ypos value (pixels).
REQ-003 SHALL have parameter TIMEOUT, default 100000: idle-cycle limit between bytes of one packet.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is synchronous to its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port rx_data, input, 8: received PS/2 mouse byte.
REQ-007 SHALL have port rx_valid, input, 1: one-cycle strobe; rx_data is valid in this cycle.
REQ-008 SHALL have port xpos, output, 12: absolute cursor X, 0..X_MAX.
REQ-009 SHALL have port ypos, output, 12: absolute cursor Y, 0..Y_MAX, with 0 at the top of the screen.
REQ-010 SHALL have port left_mouse, output, 1: left button level.
REQ-011 SHALL have port right_mouse, output, 1: right button level.
REQ-012 SHALL have port pos_valid, output, 1: one-cycle pulse when outputs update from a packet.
REQ-013 SHALL have port pkt_error, output, 1: one-cycle pulse on a sync error or timeout.

Function
REQ-014 SHALL implement the FSM states WAIT_B0, WAIT_B1, WAIT_B2 and UPDATE.
REQ-015 In WAIT_B0, on rx_valid with rx_data[3]=1, SHALL store the status byte and go to WAIT_B1.
REQ-016 In WAIT_B0, on rx_valid with rx_data[3]=0, SHALL discard the byte, pulse pkt_error next cycle and stay in WAIT_B0.
REQ-017 In WAIT_B1, on rx_valid, SHALL store the X delta and go to WAIT_B2.
REQ-018 In WAIT_B2, on rx_valid, SHALL store the Y delta and go to UPDATE.
REQ-019 SHALL leave UPDATE unconditionally after one cycle, returning to WAIT_B0.
REQ-020 SHALL ignore any rx_valid that arrives while in UPDATE.
REQ-021 Status bit mapping SHALL be: bit0 left, bit1 right, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
REQ-022 Each delta SHALL be formed as a 9-bit two's-complement value {sign, data byte}, range -256..+255.
REQ-023 SHALL force a delta to 0 when its overflow bit is set; buttons still update.
REQ-024 SHALL compute the new X as xpos + dx in at least 14-bit signed arithmetic.
REQ-025 SHALL compute the new Y as ypos - dy, because PS/2 +Y is up.
REQ-026 SHALL saturate X to 0 when below 0 and to X_MAX when above X_MAX.
REQ-027 SHALL saturate Y to 0 when below 0 and to Y_MAX when above Y_MAX.
REQ-028 In UPDATE, SHALL register xpos, ypos, left_mouse and right_mouse, with pos_valid=1 in the same cycle the new values appear.
REQ-029 Latency from the third-byte rx_valid cycle to the pos_valid and updated-output cycle SHALL be 2 clocks.
REQ-030 SHALL hold xpos, ypos and the button outputs stable between packets.
REQ-031 An idle counter SHALL count cycles without rx_valid while in WAIT_B1 or WAIT_B2, and clear on rx_valid or on entry to WAIT_B0.
REQ-032 When the idle counter reaches TIMEOUT-1, SHALL return to WAIT_B0, discard the partial packet and pulse pkt_error; outputs are unchanged.
REQ-033 If rx_valid and the timeout occur in the same cycle, the byte SHALL win and the counter SHALL clear.
REQ-034 pos_valid and pkt_error SHALL never both be asserted in the same cycle.

Reset
REQ-035 On rst=1 at a clock edge, SHALL go to WAIT_B0 and clear the idle counter and the stored bytes.
REQ-036 On reset, SHALL set xpos=X_MAX/2 and ypos=Y_MAX/2 (integer division).
REQ-037 On reset, SHALL set left_mouse, right_mouse, pos_valid and pkt_error to 0.
REQ-038 Reset mid-packet SHALL discard the partial packet with no pulse on pos_valid or pkt_error.

Structure
REQ-039 Screen-size constants (1024, 768) and the PS/2 status-bit index constants SHALL live in vga_pkg.
REQ-040 The FSM state enum typedef SHALL live in vga_pkg.
REQ-041 The clamp-and-accumulate logic SHALL be one sub-module, mouse_clamp, with inputs pos, delta and max and output clamped pos; used twice.
REQ-042 The FSM and idle counter SHALL remain in mouse_tracker.

Verification
REQ-043 After reset, bytes 0x08,0x0A,0x05 -> xpos=521, ypos=378, left=0, pos_valid pulses once, 2 clocks after the third byte.
REQ-044 From (511,383), bytes 0x39,0x00,0x80 (dx=-256, dy=-128) -> xpos=255, ypos=511, left=1.
REQ-045 From (1000,10), bytes 0x08,0x7F,0x7F -> xpos=1023, ypos=0 (both saturated).
REQ-046 Byte 0x00 in WAIT_B0 -> pkt_error pulse, no pos_valid; then 0x08,0x01,0x00 -> xpos increments by 1.
REQ-047 With TIMEOUT=16, byte 0x08 then 16 idle cycles -> pkt_error pulse; the next 0x09,0x00,0x00 is parsed as a new packet -> left=1.
REQ-048 Byte 0xC9 with nonzero deltas -> position unchanged, left=1, pos_valid pulses.
REQ-049 rst asserted after the second byte -> outputs at reset values, no pos_valid or pkt_error pulse.
